// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the GRF write-tracking scoreboard: register count,
// default parameter values and the pipeline's named Tuse/Tnew timings.
package reg_scoreboard_pkg;
  localparam int NREG       = 32;
  localparam int TW_DEF     = 2;
  localparam int MAXOUT_DEF = 3;

  localparam int TUSE_BR   = 0;
  localparam int TUSE_ALU  = 1;
  localparam int TNEW_ALU  = 1;
  localparam int TNEW_LOAD = 2;
endpackage

// File: rtl/sb_entry.sv
// One GRF register's tracking state: outstanding-write count and the
// countdown until the newest in-flight result becomes forwardable.
module sb_entry #(
  parameter int TW     = 2,
  parameter int MAXOUT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          issue_hit,
  input  logic [TW-1:0] issue_tnew,
  input  logic          wb_hit,
  output logic          pending,
  output logic [TW-1:0] tn,
  output logic          overflow
);
  localparam int OCW = $clog2(MAXOUT + 1);

  logic [OCW-1:0] oc_reg, oc_next;
  logic [TW-1:0]  tn_reg, tn_next;
  logic           wb_ok;

  // A writeback with nothing outstanding is stale and must not underflow.
  assign wb_ok = wb_hit & (oc_reg != '0);

  always_comb begin
    oc_next  = oc_reg;
    tn_next  = (tn_reg != '0) ? tn_reg - TW'(1) : tn_reg;
    overflow = 1'b0;
    if (issue_hit) begin
      tn_next = issue_tnew;
      if (!wb_ok) begin
        if (oc_reg == OCW'(MAXOUT))
          overflow = 1'b1;
        else
          oc_next = oc_reg + OCW'(1);
      end
    end else if (wb_ok) begin
      oc_next = oc_reg - OCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      oc_reg <= '0;
      tn_reg <= '0;
    end else begin
      oc_reg <= oc_next;
      tn_reg <= tn_next;
    end
  end

  assign pending = (oc_reg != '0);
  assign tn      = tn_reg;
endmodule

// File: rtl/reg_scoreboard.sv
// GRF hazard scoreboard: tracks in-flight writes for registers 1..31 and
// derives decode stall and forwarding-required flags from them.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int TW     = TW_DEF,
  parameter int MAXOUT = MAXOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [4:0]    issue_rd,
  input  logic [TW-1:0] issue_tnew,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [TW-1:0] rs_tuse,
  input  logic [TW-1:0] rt_tuse,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic          flush,
  output logic          stall,
  output logic          rs_busy,
  output logic          rt_busy,
  output logic          err
);
  logic [NREG-1:0] pending;
  logic [NREG-1:0] overflow;
  logic [TW-1:0]   tn [NREG];
  logic            issue_ok;
  logic            rs_late, rt_late;
  logic            err_reg;

  // Register 0 is hardwired to zero and never tracked.
  assign pending[0]  = 1'b0;
  assign overflow[0] = 1'b0;
  assign tn[0]       = '0;

  // stall depends only on registered state and decode sources, so gating
  // issue with it forms no combinational loop.
  assign issue_ok = issue_valid & ~stall & (issue_rd != 5'd0);

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
      sb_entry #(.TW(TW), .MAXOUT(MAXOUT)) u_entry (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .issue_hit  (issue_ok & (issue_rd == 5'(gi))),
        .issue_tnew (issue_tnew),
        .wb_hit     (wb_en & (wb_addr == 5'(gi))),
        .pending    (pending[gi]),
        .tn         (tn[gi]),
        .overflow   (overflow[gi])
      );
    end
  endgenerate

  assign rs_busy = (rs != 5'd0) & pending[rs];
  assign rt_busy = (rt != 5'd0) & pending[rt];
  assign rs_late = tn[rs] > rs_tuse;
  assign rt_late = tn[rt] > rt_tuse;
  assign stall   = (rs_busy & rs_late) | (rt_busy & rt_late);

  // Sticky; a flush cancels the overflowing issue, so it cannot set err.
  always_ff @(posedge clk) begin
    if (reset)
      err_reg <= 1'b0;
    else if (!flush && (|overflow))
      err_reg <= 1'b1;
  end

  assign err = err_reg;
endmodule
